// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the byte-serial add/sub controller.
package alu_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ADD  = 2'b00,
      ADDC = 2'b01,
      SUB  = 2'b10,
      SUBC = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic logic is_sub_op(input alu_op_e op);
      return (op == SUB) || (op == SUBC);
   endfunction

   // Carry seeded into byte 0: subtraction is A + ~B + 1, so borrow-in
   // becomes a carry-in of ~cin.
   function automatic logic init_carry(input alu_op_e op, input logic cin);
      logic c;
      case (op)
         ADD:     c = 1'b0;
         ADDC:    c = cin;
         SUB:     c = 1'b1;
         SUBC:    c = ~cin;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle for alu_seq_ctrl.
// Carries rsp_z only when ALU_SEQ_CTRL_ZFLAG_EN is defined.
interface alu_seq_ctrl_if #(parameter int NBYTES = 4);

   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_op;
   logic [8*NBYTES-1:0]   req_a;
   logic [8*NBYTES-1:0]   req_b;
   logic                  req_cin;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [8*NBYTES-1:0]   rsp_sum;
   logic                  rsp_co;
   logic                  rsp_ov;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
   logic                  rsp_z;

   modport master (
      output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ov, rsp_z
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ov, rsp_z
   );
`else
   modport master (
      output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ov
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_ov
   );
`endif

endinterface

// File: rtl/alu_byte_slice.sv
// Combinational 8-bit add slice; sub inverts b so the caller only has to
// supply the right carry-in.
module alu_byte_slice
   import alu_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   input  logic              sub,
   output logic [BYTE_W-1:0] sum,
   output logic              cout,
   output logic              ov
);

   logic [BYTE_W-1:0] b_eff;
   logic [BYTE_W:0]   full;

   // Add with optional operand inversion; overflow when both operands share
   // a sign the result does not (equivalent to carry-in xor carry-out of MSB).
   always_comb begin
      b_eff = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, b_eff} + {{BYTE_W{1'b0}}, cin};
      sum   = full[BYTE_W-1:0];
      cout  = full[BYTE_W];
      ov    = (a[BYTE_W-1] == b_eff[BYTE_W-1]) && (sum[BYTE_W-1] != a[BYTE_W-1]);
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Byte-serial add/sub controller: one byte per RUN cycle through one shared
// slice, LSB first. Optional zero flag under ALU_SEQ_CTRL_ZFLAG_EN.
//
// state | meaning
// IDLE  | ready for a request, operands latched on accept
// RUN   | one byte through the slice per cycle
// DONE  | result held until the consumer takes it
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic          clk,
   input  logic          rst,
   alu_seq_ctrl_if.slave bus
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   state_e          state_q, state_d;
   alu_op_e         op_q;
   logic [W-1:0]    a_q, b_q, sum_q;
   logic            carry_q;
   logic [IW-1:0]   idx_q;
   logic            co_q, ov_q;
   logic            sub_q;

   logic [BYTE_W-1:0] s_sum;
   logic              s_cout, s_ov;
   logic              last_byte;

   assign sub_q     = is_sub_op(op_q);
   assign last_byte = (idx_q == LAST_IDX);

   alu_byte_slice u_slice (
      .a    (a_q[idx_q*BYTE_W +: BYTE_W]),
      .b    (b_q[idx_q*BYTE_W +: BYTE_W]),
      .cin  (carry_q),
      .sub  (sub_q),
      .sum  (s_sum),
      .cout (s_cout),
      .ov   (s_ov)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = RUN;
         RUN:     if (last_byte)     state_d = DONE;
         DONE:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture on accept, byte-serial accumulate in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= ADD;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q    <= alu_op_e'(bus.req_op);
                  a_q     <= bus.req_a;
                  b_q     <= bus.req_b;
                  carry_q <= init_carry(alu_op_e'(bus.req_op), bus.req_cin);
                  idx_q   <= '0;
               end
            end
            RUN: begin
               sum_q[idx_q*BYTE_W +: BYTE_W] <= s_sum;
               carry_q <= s_cout;
               if (last_byte) begin
                  idx_q <= '0;
                  co_q  <= sub_q ? ~s_cout : s_cout;
                  ov_q  <= s_ov;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_SEQ_CTRL_ZFLAG_EN
   logic z_q;

   // Zero flag built one byte at a time; seeded to 1 on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z_q <= 1'b0;
      end else if (state_q == IDLE && bus.req_valid) begin
         z_q <= 1'b1;
      end else if (state_q == RUN) begin
         z_q <= z_q & (s_sum == '0);
      end
   end

   assign bus.rsp_z = z_q;
`endif

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == DONE);
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_co    = co_q;
   assign bus.rsp_ov    = ov_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl (NBYTES=4); checks rsp_z when
// ALU_SEQ_CTRL_ZFLAG_EN is defined.
module tb_alu_seq_ctrl;

   logic clk;
   logic rst;

   alu_seq_ctrl_if #(.NBYTES(4)) bus ();

   alu_seq_ctrl #(.NBYTES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        co;
      logic        ov;
      logic        z;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (bus.rsp_valid) break;
      end
   endtask

   task automatic check_rsp(input vec_t v, input string tag);
      chk({tag, " sum"}, 64'(bus.rsp_sum), 64'(v.sum));
      chk({tag, " co"}, 64'(bus.rsp_co), 64'(v.co));
      chk({tag, " ov"}, 64'(bus.rsp_ov), 64'(v.ov));
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
      chk({tag, " z"}, 64'(bus.rsp_z), 64'(v.z));
`endif
      chk({tag, " req_ready in DONE"}, 64'(bus.req_ready), 64'd0);
   endtask

   task automatic do_txn(input vec_t v, input string tag);
      int lat;
      bus.req_op    = v.op;
      bus.req_a     = v.a;
      bus.req_b     = v.b;
      bus.req_cin   = v.cin;
      bus.req_valid = 1'b1;
      chk({tag, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      // scramble inputs after acceptance: must not disturb result
      bus.req_valid = 1'b0;
      bus.req_op    = ~v.op;
      bus.req_a     = ~v.a;
      bus.req_b     = ~v.b;
      bus.req_cin   = ~v.cin;
      wait_rsp(lat);
      chk({tag, " latency"}, 64'(lat), 64'd4);
      check_rsp(v, tag);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk({tag, " rsp_valid after take"}, 64'(bus.rsp_valid), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic seen;
      vec_t v;

      //         op     a             b             cin   sum           co    ov    z
      vecs[0]  = '{2'b00, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{2'b10, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{2'b10, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{2'b01, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{2'b11, 32'h00000005, 32'h00000002, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{2'b10, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{2'b01, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{2'b11, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{2'b10, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};

      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_cin   = 1'b0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset req_ready", 64'(bus.req_ready), 64'd1);
      chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset rsp_sum", 64'(bus.rsp_sum), 64'd0);
      chk("reset rsp_co", 64'(bus.rsp_co), 64'd0);
      chk("reset rsp_ov", 64'(bus.rsp_ov), 64'd0);
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
      chk("reset rsp_z", 64'(bus.rsp_z), 64'd0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         do_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Backpressure: result held 5 cycles, pending request waits for handoff.
      v = vecs[0];
      bus.req_op = v.op; bus.req_a = v.a; bus.req_b = v.b; bus.req_cin = v.cin;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_op = 2'b00; bus.req_a = 32'h00000001; bus.req_b = 32'h00000002; bus.req_cin = 1'b0;
      wait_rsp(lat);
      chk("bp latency", 64'(lat), 64'd4);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("bp hold%0d valid", k), 64'(bus.rsp_valid), 64'd1);
         chk($sformatf("bp hold%0d sum", k), 64'(bus.rsp_sum), 64'(v.sum));
         chk($sformatf("bp hold%0d req_ready", k), 64'(bus.req_ready), 64'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("bp handoff rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("bp handoff req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("bp second accepted", 64'(bus.req_ready), 64'd0);
      wait_rsp(lat);
      chk("bp second latency", 64'(lat), 64'd4);
      chk("bp second sum", 64'(bus.rsp_sum), 64'h3);
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;

      // Reset during the second RUN cycle discards the operation.
      bus.req_op = 2'b10; bus.req_a = 32'h00000010; bus.req_b = 32'h00000001; bus.req_cin = 1'b0;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid-run reset req_ready", 64'(bus.req_ready), 64'd1);
      chk("mid-run reset rsp_sum", 64'(bus.rsp_sum), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid) seen = 1'b1;
      end
      chk("mid-run reset no rsp_valid", 64'(seen), 64'd0);
      do_txn(vecs[6], "post-reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, operand width in bytes (legal range 1..8).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port req_op  input  2  00 add, 01 addc, 10 sub, 11 subc.
REQ-007 SHALL have port req_a  input  8*NBYTES  operand A.
REQ-008 SHALL have port req_b  input  8*NBYTES  operand B.
REQ-009 SHALL have port req_cin  input  1  carry-in (addc) or borrow-in (subc).
REQ-010 SHALL have port rsp_valid  output  1  result present.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-012 SHALL have port rsp_sum  output  8*NBYTES  result.
REQ-013 SHALL have port rsp_co  output  1  carry-out (add ops) or borrow-out (sub ops).
REQ-014 SHALL have port rsp_ov  output  1  signed overflow of full-width operation.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DONE; one byte processed per RUN cycle, LSB first, through a single shared 8-bit adder slice.
REQ-016 IDLE: req_ready=1; on req_valid&req_ready latch op, A, B, cin; byte index=0; go RUN.
REQ-017 Initial chain carry: add 0; addc req_cin; sub 1; subc ~req_cin. Sub ops feed ~B byte into slice.
REQ-018 RUN: each cycle write slice sum into byte[index] of result register, register slice carry as next carry, increment index; after byte NBYTES-1 go DONE.
REQ-019 rsp_ov SHALL be slice overflow of byte NBYTES-1 (carry into MSB xor carry out of MSB); rsp_co = final carry for add ops, inverted final carry for sub ops.
REQ-020 Latency: rsp_valid SHALL rise exactly NBYTES cycles after the accepting edge.
REQ-021 DONE: rsp_valid=1, rsp_sum/co/ov stable until rsp_valid&rsp_ready, then IDLE.
REQ-022 req_ready SHALL be 0 in RUN and DONE; no request accepted in the DONE->IDLE handoff cycle.
REQ-023 req_* changes after acceptance SHALL not affect the in-flight result.
REQ-024 NBYTES=1 SHALL spend one RUN cycle.

Reset
REQ-025 rst SHALL force IDLE immediately, including mid-RUN or DONE; in-flight op discarded.
REQ-026 Reset values: req_ready 1, rsp_valid 0, rsp_sum 0, rsp_co 0, rsp_ov 0, index 0, rsp_z 0 (when present).

Configuration
REQ-027 Macro ALU_SEQ_CTRL_ZFLAG_EN defined: SHALL add output rsp_z (1 bit), 1 iff rsp_sum==0, valid with rsp_valid, computed incrementally per byte (no wide compare).
REQ-028 Macro undefined: rsp_z port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package alu_seq_pkg SHALL hold op enum (ADD, ADDC, SUB, SUBC), FSM state enum, and byte-width constant 8.
REQ-030 Sub-module alu_byte_slice SHALL contain combinational 8-bit add: inputs a, b, cin, sub; outputs sum, cout, ov; the controller instantiates exactly one.

Verification (NBYTES=4)
REQ-031 add 0x000000FF+0x00000001 -> sum 0x00000100, co 0, ov 0, rsp_valid 4 cycles after accept.
REQ-032 add 0xFFFFFFFF+0x00000001 -> sum 0x00000000, co 1, ov 0, z 1 (ZFLAG_EN).
REQ-033 sub 0x80000000-0x00000001 -> sum 0x7FFFFFFF, co 0, ov 1; sub 0x00000000-0x00000001 -> 0xFFFFFFFF, co 1, ov 0.
REQ-034 addc 0x7FFFFFFF+0x00000000 cin 1 -> 0x80000000, ov 1; subc 0x00000005-0x00000002 cin 1 -> 0x00000002, co 0.
REQ-035 rsp_ready low 5 cycles -> result held stable, req_ready 0 throughout; second req_valid accepted only after handoff cycle.
REQ-036 rst pulse at 2nd RUN cycle -> IDLE next edge, rsp_valid never asserts, next request completes correctly.
